// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV control unit: states, instruction
// fields, datapath select codes and trap causes.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_EXEC_I  = 4'd4,
    S_ALU_WB  = 4'd5,
    S_ADDR    = 4'd6,
    S_MEM_RD  = 4'd7,
    S_WB_LOAD = 4'd8,
    S_MEM_WR  = 4'd9,
    S_EXEC_BR = 4'd10,
    S_LUI_WB  = 4'd11,
    S_TRAP    = 4'd12,
    S_HALT    = 4'd13
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_CMP  = 3'b111;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;

  localparam logic [1:0] M2R_AOUT  = 2'b00;
  localparam logic [1:0] M2R_MDR   = 2'b01;
  localparam logic [1:0] M2R_IMM   = 2'b10;
  localparam logic [1:0] M2R_SHIFT = 2'b11;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_REG  = 2'b01;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_FETCH_TO = 2'b10;
  localparam logic [1:0] CAUSE_DATA_TO  = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request/acknowledge handshake between the control unit and memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ack;

  modport master (output mem_req, output mem_we, input mem_ack);
  modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Wait-state counter for memory handshakes; flags when MEM_TIMEOUT cycles
// have passed without an acknowledge.
module mem_wait_timer #(
  parameter int CNT_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign timeout = (count_q == CNT_W'(MEM_TIMEOUT));

  // Saturate at the timeout value so the counter never wraps back to zero.
  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && !timeout)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV control unit: sequences fetch/decode/execute/memory/writeback
// with a timed memory handshake, trap path, ebreak halt and retire counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_if.master    mem,
  input  logic [31:0]          instr,
  input  logic                 alu_zero,
  input  logic                 alu_lt,
  input  logic                 dbg_resume,
  output logic                 ir_load,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic                 load_a,
  output logic                 load_b,
  output logic                 load_aout,
  output logic                 load_mdr,
  output logic [1:0]           pc_src,
  output logic [1:0]           mem_to_reg,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_fct,
  output logic [1:0]           shift,
  output logic [3:0]           state_o,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);

  state_t                state_q, state_d;
  logic [1:0]            trap_cause_q, trap_cause_d;
  logic [INSTRET_W-1:0]  instret_q, instret_d;
  logic                  mem_req, mem_we, retire, timeout;
  logic [1:0]            cause_next;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       r_legal, i_legal, br_legal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  assign r_legal  = (f7 == F7_BASE && (f3 == F3_ADD || f3 == F3_AND || f3 == F3_SLT)) ||
                    (f7 == F7_ALT && f3 == F3_ADD);
  assign i_legal  = (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_SLL) || (f3 == F3_SR);
  assign br_legal = (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);

  mem_wait_timer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_d != state_q),
    .en      (mem_req && !mem.mem_ack),
    .timeout (timeout)
  );

  always_comb begin
    state_d    = state_q;
    cause_next = CAUSE_NONE;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_aout  = 1'b0;
    load_mdr   = 1'b0;
    pc_src     = PC_ALU;
    mem_to_reg = M2R_AOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    alu_fct    = ALU_PASS;
    shift      = SH_SLL;
    trap       = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_4;
        alu_fct   = ALU_ADD;
        if (mem.mem_ack) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_ALU;
          state_d  = S_DECODE;
        end else if (timeout) begin
          cause_next = CAUSE_FETCH_TO;
          state_d    = S_TRAP;
        end
      end

      S_DECODE: begin
        load_a    = 1'b1;
        load_b    = 1'b1;
        load_aout = 1'b1;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_BOFF;
        alu_fct   = ALU_ADD;
        cause_next = CAUSE_ILLEGAL;
        state_d    = S_TRAP;
        if (instr == INSTR_NOP) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          case (opcode)
            OP_R:              if (r_legal) state_d = S_EXEC_R;
            OP_I:              if (i_legal) state_d = S_EXEC_I;
            OP_LOAD, OP_STORE: state_d = S_ADDR;
            OP_BRANCH:         if (br_legal) state_d = S_EXEC_BR;
            OP_LUI:            state_d = S_LUI_WB;
            OP_SYSTEM: begin
              retire  = 1'b1;
              state_d = S_HALT;
            end
            default:           state_d = S_TRAP;
          endcase
        end
      end

      S_EXEC_R: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        load_aout = 1'b1;
        state_d   = S_ALU_WB;
        if (f3 == F3_SLT) begin
          alu_fct    = ALU_CMP;
          reg_write  = 1'b1;
          mem_to_reg = M2R_IMM;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end else if (f3 == F3_AND)
          alu_fct = ALU_AND;
        else if (f7 == F7_ALT)
          alu_fct = ALU_SUB;
        else
          alu_fct = ALU_ADD;
      end

      S_EXEC_I: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        load_aout = 1'b1;
        if (f3 == F3_ADD) begin
          alu_fct = ALU_ADD;
          state_d = S_ALU_WB;
        end else begin
          // slti and shifts bypass AluOut and write the register file now.
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
          if (f3 == F3_SLT) begin
            alu_fct    = ALU_CMP;
            mem_to_reg = M2R_IMM;
          end else begin
            mem_to_reg = M2R_SHIFT;
            shift      = (f3 == F3_SLL) ? SH_SLL : (f7[5] ? SH_SRA : SH_SRL);
          end
        end
      end

      S_ALU_WB, S_WB_LOAD, S_LUI_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (state_q == S_WB_LOAD) ? M2R_MDR :
                     (state_q == S_LUI_WB)  ? M2R_IMM : M2R_AOUT;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_ADDR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        alu_fct   = ALU_ADD;
        load_aout = 1'b1;
        state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD, S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = (state_q == S_MEM_WR);
        if (mem.mem_ack) begin
          load_mdr = (state_q == S_MEM_RD);
          retire   = (state_q == S_MEM_WR);
          state_d  = (state_q == S_MEM_RD) ? S_WB_LOAD : S_FETCH;
        end else if (timeout) begin
          cause_next = CAUSE_DATA_TO;
          state_d    = S_TRAP;
        end
      end

      S_EXEC_BR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_REG;
        alu_fct   = ALU_SUB;
        pc_src    = PC_BR;
        case (f3)
          F3_BEQ:  pc_write = alu_zero;
          F3_BNE:  pc_write = !alu_zero;
          F3_BLT:  pc_write = alu_lt;
          default: pc_write = !alu_lt;
        endcase
        retire  = 1'b1;
        state_d = S_FETCH;
      end

      S_TRAP: begin
        trap     = 1'b1;
        pc_write = 1'b1;
        pc_src   = PC_TRAP;
        state_d  = S_FETCH;
      end

      S_HALT: begin
        halted = 1'b1;
        if (dbg_resume) state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase

    trap_cause_d = (state_d == S_TRAP) ? cause_next : trap_cause_q;
    instret_d    = retire ? instret_q + 1'b1 : instret_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_RST;
      trap_cause_q <= CAUSE_NONE;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
      instret_q    <= instret_d;
    end
  end

  assign mem.mem_req = mem_req;
  assign mem.mem_we  = mem_we;
  assign state_o     = state_q;
  assign trap_cause  = trap_cause_q;
  assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: steps through instruction classes,
// wait states, timeouts, traps, halt/resume and mid-operation reset.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        alu_zero, alu_lt, dbg_resume;
  logic        ir_load, pc_write, reg_write, load_a, load_b, load_aout, load_mdr;
  logic [1:0]  pc_src, mem_to_reg, alu_src_a, alu_src_b, shift, trap_cause;
  logic [2:0]  alu_fct;
  logic [3:0]  state_o;
  logic        trap, halted;
  logic [31:0] instret;

  int checks_total  = 0;
  int checks_passed = 0;

  multicycle_ctrl_if mem_bus();

  multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4), .INSTRET_W(32)) dut (
    .clk(clk), .reset(reset), .mem(mem_bus), .instr(instr),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .dbg_resume(dbg_resume),
    .ir_load(ir_load), .pc_write(pc_write), .reg_write(reg_write),
    .load_a(load_a), .load_b(load_b), .load_aout(load_aout), .load_mdr(load_mdr),
    .pc_src(pc_src), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_fct(alu_fct), .shift(shift), .state_o(state_o),
    .trap(trap), .trap_cause(trap_cause), .halted(halted), .instret(instret)
  );

  always #5 clk = ~clk;

  logic [29:0] ctrl_vec;
  assign ctrl_vec = {mem_bus.mem_req, mem_bus.mem_we, ir_load, pc_write, reg_write,
                     load_a, load_b, load_aout, load_mdr, pc_src, mem_to_reg,
                     alu_src_a, alu_src_b, alu_fct, shift, state_o, trap,
                     trap_cause, halted};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  // Starting in a FETCH cycle: zero-wait fetch, decode, then one EXEC_BR cycle.
  task automatic run_branch(input string tag, input logic [31:0] ins,
                            input logic z, input logic lt, input logic exp_pcw);
    instr = ins; mem_bus.mem_ack = 1'b1; #1;
    check({tag, "_fetch"}, 32'(state_o), 32'(S_FETCH));
    nxt(); mem_bus.mem_ack = 1'b0; #1;
    check({tag, "_decode"}, 32'(state_o), 32'(S_DECODE));
    nxt(); alu_zero = z; alu_lt = lt; #1;
    check({tag, "_state"}, 32'(state_o), 32'(S_EXEC_BR));
    check({tag, "_pc_write"}, 32'(pc_write), 32'(exp_pcw));
    check({tag, "_pc_src"}, 32'(pc_src), 32'(PC_BR));
    check({tag, "_alu_fct"}, 32'(alu_fct), 32'(ALU_SUB));
    nxt(); alu_zero = 1'b0; alu_lt = 1'b0; #1;
    check({tag, "_back_fetch"}, 32'(state_o), 32'(S_FETCH));
    $display("txn %s: instr=0x%08h zero=%0b lt=%0b pc_write=%0b", tag, ins, z, lt, pc_write);
  endtask

  initial begin
    reset = 1'b0; instr = 32'h0; mem_bus.mem_ack = 1'b0;
    alu_zero = 1'b0; alu_lt = 1'b0; dbg_resume = 1'b0;
    #3;
    check("rst_ctrl", {2'b00, ctrl_vec}, 32'h0);
    check("rst_instret", instret, 32'h0);
    @(negedge clk); reset = 1'b1;
    nxt();

    // add x3,x1,x2 with zero-wait fetch
    instr = 32'h002081B3; mem_bus.mem_ack = 1'b1; #1;
    check("add_fetch_state", 32'(state_o), 32'(S_FETCH));
    check("add_fetch_irload", 32'(ir_load), 32'd1);
    check("add_fetch_pcwrite", 32'(pc_write), 32'd1);
    nxt(); mem_bus.mem_ack = 1'b0; #1;
    check("add_decode_state", 32'(state_o), 32'(S_DECODE));
    check("add_decode_loads", {29'd0, load_a, load_b, load_aout}, 32'h7);
    nxt(); #1;
    check("add_exec_state", 32'(state_o), 32'(S_EXEC_R));
    check("add_exec_fct", 32'(alu_fct), 32'(ALU_ADD));
    nxt(); #1;
    check("add_wb_state", 32'(state_o), 32'(S_ALU_WB));
    check("add_wb_regwrite", 32'(reg_write), 32'd1);
    check("add_wb_m2r", 32'(mem_to_reg), 32'(M2R_AOUT));
    check("add_wb_instret", instret, 32'd0);
    nxt(); #1;
    check("add_done_state", 32'(state_o), 32'(S_FETCH));
    check("add_instret", instret, 32'd1);
    $display("txn add: instret=%0d", instret);

    // lw x3,0(x1) with 3 wait states in FETCH and MEM_RD
    instr = 32'h0000A183;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) nxt();
      mem_bus.mem_ack = (i == 3); #1;
      check("lw_fetch_state", 32'(state_o), 32'(S_FETCH));
      check("lw_fetch_req", 32'(mem_bus.mem_req), 32'd1);
    end
    nxt(); mem_bus.mem_ack = 1'b0; #1;
    check("lw_decode_state", 32'(state_o), 32'(S_DECODE));
    nxt(); #1;
    check("lw_addr_state", 32'(state_o), 32'(S_ADDR));
    check("lw_addr_srcb", 32'(alu_src_b), 32'(SRCB_IMM));
    for (int i = 0; i < 4; i++) begin
      nxt();
      mem_bus.mem_ack = (i == 3); #1;
      check("lw_rd_state", 32'(state_o), 32'(S_MEM_RD));
      check("lw_rd_req", 32'(mem_bus.mem_req), 32'd1);
      check("lw_rd_mdr", 32'(load_mdr), 32'(i == 3));
    end
    nxt(); mem_bus.mem_ack = 1'b0; #1;
    check("lw_wb_state", 32'(state_o), 32'(S_WB_LOAD));
    check("lw_wb_regwrite", 32'(reg_write), 32'd1);
    check("lw_wb_m2r", 32'(mem_to_reg), 32'(M2R_MDR));
    check("lw_wb_trap", 32'(trap), 32'd0);
    nxt(); #1;
    check("lw_instret", instret, 32'd2);
    check("lw_cause", 32'(trap_cause), 32'(CAUSE_NONE));
    $display("txn lw: instret=%0d", instret);

    run_branch("beq_taken",  32'h00208063, 1'b1, 1'b0, 1'b1);
    run_branch("beq_not",    32'h00208063, 1'b0, 1'b0, 1'b0);
    run_branch("blt_taken",  32'h0020C063, 1'b0, 1'b1, 1'b1);
    check("br_instret", instret, 32'd5);

    // fetch timeout: 16 FETCH cycles without ack, then TRAP
    for (int i = 0; i < 16; i++) begin
      if (i > 0) nxt();
      #1;
      check("to_fetch_state", 32'(state_o), 32'(S_FETCH));
    end
    nxt(); #1;
    check("to_trap_state", 32'(state_o), 32'(S_TRAP));
    check("to_trap_pulse", 32'(trap), 32'd1);
    check("to_trap_pcsrc", 32'(pc_src), 32'(PC_TRAP));
    check("to_trap_pcwrite", 32'(pc_write), 32'd1);
    check("to_trap_cause", 32'(trap_cause), 32'(CAUSE_FETCH_TO));
    check("to_trap_instret", instret, 32'd5);
    nxt(); #1;
    check("to_back_fetch", 32'(state_o), 32'(S_FETCH));
    check("to_trap_drop", 32'(trap), 32'd0);
    $display("txn fetch_timeout: cause=%0b", trap_cause);

    // ack on the 16th cycle wins over the timeout
    instr = INSTR_NOP;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) nxt();
      mem_bus.mem_ack = (i == 15); #1;
      check("late_fetch_state", 32'(state_o), 32'(S_FETCH));
    end
    nxt(); mem_bus.mem_ack = 1'b0; #1;
    check("late_decode_state", 32'(state_o), 32'(S_DECODE));
    check("late_no_trap", 32'(trap), 32'd0);
    nxt(); #1;
    check("nop_state", 32'(state_o), 32'(S_FETCH));
    check("nop_instret", instret, 32'd6);
    check("nop_cause_held", 32'(trap_cause), 32'(CAUSE_FETCH_TO));
    $display("txn late_ack_nop: instret=%0d", instret);

    // illegal opcode
    instr = 32'h0000007F; mem_bus.mem_ack = 1'b1; #1;
    nxt(); mem_bus.mem_ack = 1'b0; #1;
    check("ill_decode_state", 32'(state_o), 32'(S_DECODE));
    nxt(); #1;
    check("ill_trap_state", 32'(state_o), 32'(S_TRAP));
    check("ill_trap_pulse", 32'(trap), 32'd1);
    check("ill_cause", 32'(trap_cause), 32'(CAUSE_ILLEGAL));
    check("ill_instret", instret, 32'd6);
    nxt(); #1;
    check("ill_back_fetch", 32'(state_o), 32'(S_FETCH));
    $display("txn illegal: cause=%0b", trap_cause);

    // ebreak -> HALT, resume after 5 cycles
    instr = 32'h00100073; mem_bus.mem_ack = 1'b1; #1;
    nxt(); mem_bus.mem_ack = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      nxt();
      dbg_resume = (i == 4); #1;
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_state", 32'(state_o), 32'(S_HALT));
    end
    check("halt_instret", instret, 32'd7);
    nxt(); dbg_resume = 1'b0; #1;
    check("resume_state", 32'(state_o), 32'(S_FETCH));
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_instret", instret, 32'd7);
    $display("txn ebreak: instret=%0d", instret);

    // sw, reset asserted while in MEM_WR
    instr = 32'h0020A023; mem_bus.mem_ack = 1'b1; #1;
    nxt(); mem_bus.mem_ack = 1'b0; #1;
    nxt(); #1;
    check("sw_addr_state", 32'(state_o), 32'(S_ADDR));
    nxt(); #1;
    check("sw_wr_state", 32'(state_o), 32'(S_MEM_WR));
    check("sw_wr_req_we", {30'd0, mem_bus.mem_req, mem_bus.mem_we}, 32'h3);
    reset = 1'b0; #1;
    check("midrst_ctrl", {2'b00, ctrl_vec}, 32'h0);
    check("midrst_instret", instret, 32'h0);
    nxt(); reset = 1'b1;
    nxt(); #1;
    check("postrst_state", 32'(state_o), 32'(S_FETCH));
    $display("txn sw_reset: state=%0d", state_o);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Next-generation multicycle RV control unit for the processor datapath. Drives the register file, ALU, PC, IR, MDR and the A/B/AluOut register loads.
- Adds a req/ack memory handshake with variable wait states and a parametrised timeout.
- Adds standard-encoded branches, an illegal-instruction and bus-error trap path, halt/resume on ebreak, and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 15, wait cycles tolerated without mem_ack before a bus-error trap (1..2^CNT_W-1)
CNT_W, 4, width of the wait-state counter
INSTRET_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
instr  in  32  IR contents (opcode/func3/func7 decoded internally)
mem_ack  in  1  memory completes the current request this cycle
alu_zero  in  1  ALU result == 0
alu_lt  in  1  signed A < B from the ALU
dbg_resume  in  1  leave HALT
mem_req, mem_we  out  1,1  memory request; write qualifier
ir_load, pc_write, reg_write, load_a, load_b, load_aout, load_mdr  out  1 each  datapath strobes
pc_src  out  2  00 ALU (PC+4), 01 AluOut (branch target), 10 trap vector
mem_to_reg  out  2  00 AluOut, 01 MDR, 10 imm/slt result, 11 shifter
alu_src_a, alu_src_b  out  2,2  A: 00 PC, 01 regA; B: 00 regB, 01 const 4, 10 imm, 11 branch offset
alu_fct  out  3  000 pass, 001 add, 010 sub, 011 and, 111 compare
shift  out  2  00 sll, 01 srl, 10 sra
state_o  out  4  current state encoding
trap  out  1  one-cycle trap pulse
trap_cause  out  2  01 illegal, 10 fetch timeout, 11 data timeout; held until next trap
halted  out  1  high in HALT
instret  out  INSTRET_W  retired-instruction count, wraps

Behaviour:
- Reset (reset=0): state RST. All outputs 0, including instret, trap_cause and the wait counter. First rising edge after release moves RST->FETCH.
- Outputs are combinational from state plus the listed inputs. Undriven controls are 0 in every state.
- FETCH:
  - mem_req=1, alu_src_a=00, alu_src_b=01, alu_fct=001.
  - On mem_ack (same cycle allowed): ir_load=1, pc_write=1, pc_src=00, go to DECODE.
- DECODE:
  - load_a=1, load_b=1, load_aout=1, alu 00/11 add (branch target).
  - Instruction 0x00000013 (NOP): retire, go to FETCH.
  - R 0110011: func7/func3 0/000 add, 0x20/000 sub, 0/111 and, 0/010 slt. Go to EXEC_R.
  - I 0010011: funct3 000 addi, 010 slti, 001 slli, 101 srli/srai (func7[5]). Go to EXEC_I.
  - 0000011 or 0100011: go to ADDR.
  - 1100011 with func3 000/001/100/101: go to EXEC_BR.
  - 0110111: go to LUI_WB.
  - 1110011: go to HALT.
  - Anything else: go to TRAP, cause 01.
- EXEC_R, EXEC_I: drive the ALU function, operands and shift for the op; load_aout=1; go to ALU_WB.
  - Exception: slt/slti/shifts write directly in this state (reg_write=1, mem_to_reg 10 or 11), retire, and go to FETCH.
- ALU_WB: reg_write=1, mem_to_reg=00, retire, go to FETCH.
- ADDR: alu 01/10 add, load_aout=1. Load goes to MEM_RD; store goes to MEM_WR.
- MEM_RD: mem_req=1. On ack: load_mdr=1, go to WB_LOAD.
- WB_LOAD: reg_write=1, mem_to_reg=01, retire, go to FETCH.
- MEM_WR: mem_req=1, mem_we=1. On ack: retire, go to FETCH.
- EXEC_BR:
  - alu 01/00 sub, pc_src=01.
  - pc_write = alu_zero for beq, !alu_zero for bne, alu_lt for blt, !alu_lt for bge.
  - Retire, go to FETCH.
- LUI_WB: reg_write=1, mem_to_reg=10, retire, go to FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle the state waits without ack.
  - When the count equals MEM_TIMEOUT and there is still no ack, the next state is TRAP (cause 10 from FETCH, 11 otherwise).
  - An ack in the same cycle as the timeout wins.
- TRAP: one cycle. trap=1, pc_write=1, pc_src=10, trap_cause registered. Go to FETCH. Not retired.
- HALT: halted=1. ebreak is counted as retired on entry. Stays in HALT until dbg_resume=1, then goes to FETCH.
- Retire: instret increments by 1 on the cycle the instruction's final state exits, modulo 2^INSTRET_W.
- Asserting reset mid-operation aborts any pending request immediately. mem_req drops asynchronously.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - state enum (4-bit);
  - opcode, func3 and func7 constants;
  - alu_fct, shift, pc_src, mem_to_reg and alu_src localparams;
  - trap cause codes.
- One sub-module, mem_wait_timer: counter with clear, enable and timeout flag, parametrised by CNT_W and MEM_TIMEOUT.

Test Plan:
- add x3,x1,x2 (0x002081B3), zero-wait ack -> states FETCH, DECODE, EXEC_R, ALU_WB; alu_fct=001 in EXEC_R; reg_write at cycle 4; instret 0->1.
- lw with mem_ack delayed 3 cycles in both FETCH and MEM_RD -> mem_req held 4 cycles each; load_mdr then reg_write with mem_to_reg=01; no trap.
- beq with alu_zero=1 -> pc_write=1, pc_src=01 in EXEC_BR. Same with alu_zero=0 -> pc_write=0. blt with alu_lt=1 -> pc_write=1.
- mem_ack never asserted in FETCH, MEM_TIMEOUT=15 -> TRAP after 16 FETCH cycles, trap_cause=10, pc_src=10. Repeat with ack on the 16th cycle -> no trap.
- Opcode 0x0000007F -> TRAP with cause 01; instret unchanged.
- ebreak (0x00100073) -> halted=1 for 5 cycles; dbg_resume pulse -> FETCH. Reset asserted mid-MEM_WR -> all outputs 0 in the same cycle.
